keccak_stream_feeder: RTL and testbench
=======================================

Name: keccak_stream_feeder

Overview:
Parametrised successor to the fixed 512-bit hash-register loader. It fetches an arbitrary-length message from OCM via the AXI burst master, buffers bus beats in an internal FIFO, and unpacks them into 64-bit lanes. It streams those lanes to the keccak core using the core's in_ready/is_last/byte_num protocol, including correct final-word padding signalling. It sits between the burst master and the keccak core inside the SHA3 burst-master top level.

Parameters:
BUS_W, 128, bus beat width in bits; must be an integer multiple of 64.
BEATS_PER_BURST, 4, beats returned per init_master_txn.
FIFO_DEPTH, 8, internal FIFO depth in beats; must be at least BEATS_PER_BURST and a power of two.
LEN_W, 16, width of the message length in bytes.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begin a message; ignored while busy
msg_len  in  LEN_W  message length in bytes, sampled on start
ocm_data_out  in  BUS_W  read beat from burst master
bus_data_valid  in  1  beat valid; written to FIFO that cycle
read_ready  out  1  FIFO free entries >= BEATS_PER_BURST
read_addr_index  out  32  burst index for the burst master (address = base + index*burst bytes)
init_master_txn  out  1  one-cycle burst request pulse
read_done  in  1  current burst complete
keccak_input  out  64  lane to keccak core
in_ready  out  1  lane valid, one cycle per lane
is_last  out  1  qualifies the final lane
byte_num  out  3  valid bytes in the final lane (0..7)
buffer_full  in  1  keccak core cannot accept
busy  out  1  message in progress
done  out  1  one-cycle pulse after the last lane is sent

Behaviour:
- Reset: all outputs are 0; both FSMs go to IDLE; the FIFO is emptied; counters are cleared. Reset mid-message aborts with no done pulse.
- Definitions: BURST_BYTES = BEATS_PER_BURST*BUS_W/8. LANES = BUS_W/64. nbursts = ceil(msg_len/BURST_BYTES). nlanes = floor(msg_len/8)+1. The final lane is always is_last.
- On start while idle: latch msg_len, set busy=1, clear read_addr_index.
- Read FSM states and transitions:
  - IDLE -> ISSUE on start.
  - ISSUE: if read_addr_index == nbursts, go to RDONE. Otherwise, if read_ready, pulse init_master_txn for one cycle and go to WAIT.
  - WAIT: on read_done, increment read_addr_index and go to ISSUE.
  - RDONE: wait for the feed FSM to finish, then go to IDLE.
- A zero-length message issues no bursts.
- FIFO:
  - Beats are written on bus_data_valid. A write while full is a protocol error; the beat is dropped and an internal sticky overflow flag is set. read_ready backpressure prevents this.
  - A simultaneous read and write while full is allowed.
- Unpacking: lanes are taken from each beat LSB-first; lane k is bits [64k+63:64k]. A lane pointer advances per lane sent, and the beat is popped after its last lane.
- Feed FSM states: IDLE, FETCH (FIFO read latency, 1 cycle), SEND, LAST, FLUSH.
- SEND:
  - Hold while buffer_full=1, with in_ready=0.
  - Otherwise drive keccak_input and in_ready=1 for one cycle, then decrement the remaining-byte count by 8.
  - Go to LAST when remaining < 8.
- LAST:
  - byte_num = remaining[2:0]. is_last=1 and in_ready=1 for one cycle, subject to the same buffer_full hold.
  - The lane data is the current FIFO lane if remaining > 0; otherwise a don't-care lane driven as 0, with no FIFO pop.
  - Then go to FLUSH.
- FLUSH:
  - Pop and discard any beats and lanes beyond msg_len until the read FSM reaches RDONE and the FIFO is empty.
  - Pulse done, clear busy, go to IDLE.
- When the FIFO is empty during SEND, stall with in_ready=0. There is no bubble limit.
- in_ready and is_last are registered outputs. Latency from the first beat written to the first in_ready is 2 cycles when buffer_full=0.
- start while busy is ignored with no side effects.

Test Plan:
- msg_len=64, counting-pattern beats, buffer_full=0:
  - 1 burst with index 0.
  - 8 lanes with is_last=0, lane i = pattern word i.
  - Then one lane with is_last=1, byte_num=0, data 0.
  - done pulse, busy low.
- msg_len=13: 1 burst. Lane0 is_last=0. Lane1 is_last=1, byte_num=5. Remaining 6 lanes are flushed. done pulse.
- msg_len=0: no init_master_txn. A single lane with is_last=1, byte_num=0. done within 4 cycles of start.
- msg_len=200, buffer_full toggled every other cycle:
  - 4 bursts with indices 0..3.
  - 25 full lanes, then is_last with byte_num=0.
  - No lane lost or duplicated; in_ready never high while buffer_full=1.
- Beats delayed so the FIFO fills with buffer_full=1:
  - read_ready drops and no init_master_txn is issued.
  - Release buffer_full: issue resumes; no overflow flag set.
- Reset asserted mid-burst:
  - All outputs are 0 the next cycle.
  - A new start with msg_len=8 completes normally: lane0 full, then is_last with byte_num=0.

Source files
------------

// File: rtl/keccak_stream_feeder.sv
// Streams an OCM message into the keccak core as 64-bit lanes: a read FSM fetches bursts
// into a beat FIFO while a feed FSM unpacks beats and signals the padded final lane.
module keccak_stream_feeder #(
    parameter int BUS_W           = 128,
    parameter int BEATS_PER_BURST = 4,
    parameter int FIFO_DEPTH      = 8,
    parameter int LEN_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic [BUS_W-1:0] ocm_data_out,
    input  logic             bus_data_valid,
    output logic             read_ready,
    output logic [31:0]      read_addr_index,
    output logic             init_master_txn,
    input  logic             read_done,
    output logic [63:0]      keccak_input,
    output logic             in_ready,
    output logic             is_last,
    output logic [2:0]       byte_num,
    input  logic             buffer_full,
    output logic             busy,
    output logic             done
);

    localparam int LANES       = BUS_W / 64;
    localparam int BURST_BYTES = BEATS_PER_BURST * BUS_W / 8;
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = AW + 1;
    localparam int LP_W        = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_DONE} rd_state_t;
    typedef enum logic [2:0] {F_IDLE, F_FETCH, F_SEND, F_LAST, F_FLUSH} fd_state_t;

    rd_state_t        rd_state_q, rd_state_d;
    fd_state_t        fd_state_q, fd_state_d;
    logic [31:0]      idx_q, idx_d, nbursts_q, nbursts_d;
    logic [31:0]      nbursts_calc_s;
    logic             init_q, init_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [BUS_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [LP_W-1:0]  lane_ptr_q, lane_ptr_d;
    logic             ovf_q, ovf_d;
    logic [63:0]      kin_q, kin_d;
    logic             in_ready_q, in_ready_d, is_last_q, is_last_d;
    logic [2:0]       byte_num_q, byte_num_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             read_ready_q, read_ready_d;
    logic             start_s, pop_s, wr_en_s, finish_s, take_lane_s, fifo_nempty_s, last_lane_s;
    logic [63:0]      lanes_s [LANES];
    logic [63:0]      lane_s;

    assign start_s        = start && !busy_q;
    assign nbursts_calc_s = (32'(msg_len) + 32'(BURST_BYTES - 1)) / 32'(BURST_BYTES);
    assign fifo_nempty_s  = (count_q != CNT_W'(0));
    assign last_lane_s    = (lane_ptr_q == LP_W'(LANES - 1));

    // Split the head beat into lanes, lane k occupying bits [64k+63:64k]
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lanes_s[k] = fifo_mem_q[rd_ptr_q][k*64 +: 64];
        end
        lane_s = lanes_s[lane_ptr_q];
    end

    // Read FSM: one burst request per index until all bursts of the message are fetched
    always_comb begin
        rd_state_d = rd_state_q;
        idx_d      = idx_q;
        nbursts_d  = nbursts_q;
        init_d     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (start_s) begin
                    idx_d      = 32'd0;
                    nbursts_d  = nbursts_calc_s;
                    rd_state_d = R_ISSUE;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_ISSUE: begin
                if (idx_q == nbursts_q) begin
                    rd_state_d = R_DONE;
                end else if (read_ready_q) begin
                    init_d     = 1'b1;
                    rd_state_d = R_WAIT;
                end else begin
                    rd_state_d = R_ISSUE;
                end
            end
            R_WAIT: begin
                if (read_done) begin
                    idx_d      = idx_q + 32'd1;
                    rd_state_d = R_ISSUE;
                end else begin
                    rd_state_d = R_WAIT;
                end
            end
            R_DONE: begin
                if (finish_s) begin
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d = R_DONE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Feed FSM: emits lanes to the core, then the is_last lane, then drains leftover beats
    always_comb begin
        fd_state_d  = fd_state_q;
        remaining_d = remaining_q;
        lane_ptr_d  = lane_ptr_q;
        kin_d       = kin_q;
        in_ready_d  = 1'b0;
        is_last_d   = 1'b0;
        byte_num_d  = 3'd0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pop_s       = 1'b0;
        finish_s    = 1'b0;
        take_lane_s = 1'b0;
        case (fd_state_q)
            F_IDLE: begin
                if (start_s) begin
                    remaining_d = msg_len;
                    lane_ptr_d  = LP_W'(0);
                    busy_d      = 1'b1;
                    fd_state_d  = F_FETCH;
                end else begin
                    fd_state_d = F_IDLE;
                end
            end
            F_FETCH: begin
                if (remaining_q < LEN_W'(8)) begin
                    fd_state_d = F_LAST;
                end else begin
                    fd_state_d = F_SEND;
                end
            end
            F_SEND: begin
                if (!buffer_full && fifo_nempty_s) begin
                    take_lane_s = 1'b1;
                    kin_d       = lane_s;
                    in_ready_d  = 1'b1;
                    remaining_d = remaining_q - LEN_W'(8);
                    if (remaining_d < LEN_W'(8)) begin
                        fd_state_d = F_LAST;
                    end else begin
                        fd_state_d = F_SEND;
                    end
                end else begin
                    fd_state_d = F_SEND;
                end
            end
            F_LAST: begin
                // An exact multiple of 8 bytes still needs an empty is_last lane for padding
                if (buffer_full) begin
                    fd_state_d = F_LAST;
                end else if (remaining_q == LEN_W'(0)) begin
                    kin_d      = 64'd0;
                    in_ready_d = 1'b1;
                    is_last_d  = 1'b1;
                    fd_state_d = F_FLUSH;
                end else if (fifo_nempty_s) begin
                    take_lane_s = 1'b1;
                    kin_d       = lane_s;
                    in_ready_d  = 1'b1;
                    is_last_d   = 1'b1;
                    byte_num_d  = remaining_q[2:0];
                    fd_state_d  = F_FLUSH;
                end else begin
                    fd_state_d = F_LAST;
                end
            end
            F_FLUSH: begin
                if (fifo_nempty_s) begin
                    pop_s      = 1'b1;
                    lane_ptr_d = LP_W'(0);
                end else if (rd_state_q == R_DONE) begin
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    finish_s   = 1'b1;
                    fd_state_d = F_IDLE;
                end else begin
                    fd_state_d = F_FLUSH;
                end
            end
            default: fd_state_d = F_IDLE;
        endcase
        if (take_lane_s) begin
            if (last_lane_s) begin
                pop_s      = 1'b1;
                lane_ptr_d = LP_W'(0);
            end else begin
                lane_ptr_d = lane_ptr_q + LP_W'(1);
            end
        end else begin
            lane_ptr_d = lane_ptr_d;
        end
    end

    // FIFO bookkeeping; a write into a full FIFO is dropped unless a pop frees the slot
    always_comb begin
        wr_en_s = bus_data_valid && ((count_q != CNT_W'(FIFO_DEPTH)) || pop_s);
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        ovf_d        = ovf_q | (bus_data_valid & ~wr_en_s);
        read_ready_d = (count_d <= CNT_W'(FIFO_DEPTH - BEATS_PER_BURST));
    end

    // Beat storage
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            fifo_mem_q[wr_ptr_q] <= ocm_data_out;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q   <= R_IDLE;
            fd_state_q   <= F_IDLE;
            idx_q        <= 32'd0;
            nbursts_q    <= 32'd0;
            init_q       <= 1'b0;
            remaining_q  <= LEN_W'(0);
            wr_ptr_q     <= AW'(0);
            rd_ptr_q     <= AW'(0);
            count_q      <= CNT_W'(0);
            lane_ptr_q   <= LP_W'(0);
            ovf_q        <= 1'b0;
            kin_q        <= 64'd0;
            in_ready_q   <= 1'b0;
            is_last_q    <= 1'b0;
            byte_num_q   <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            read_ready_q <= 1'b0;
        end else begin
            rd_state_q   <= rd_state_d;
            fd_state_q   <= fd_state_d;
            idx_q        <= idx_d;
            nbursts_q    <= nbursts_d;
            init_q       <= init_d;
            remaining_q  <= remaining_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lane_ptr_q   <= lane_ptr_d;
            ovf_q        <= ovf_d;
            kin_q        <= kin_d;
            in_ready_q   <= in_ready_d;
            is_last_q    <= is_last_d;
            byte_num_q   <= byte_num_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            read_ready_q <= read_ready_d;
        end
    end

    assign read_ready      = read_ready_q;
    assign read_addr_index = idx_q;
    assign init_master_txn = init_q;
    assign keccak_input    = kin_q;
    assign in_ready        = in_ready_q;
    assign is_last         = is_last_q;
    assign byte_num        = byte_num_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_keccak_stream_feeder.sv
// Scoreboard bench for keccak_stream_feeder: a burst-master model feeds tagged lane words,
// expected bursts/lanes are queued at start and popped by an independent monitor.
module tb_keccak_stream_feeder;

    localparam int BUS_W       = 128;
    localparam int BPB         = 4;
    localparam int LANES       = 2;
    localparam int BURST_BYTES = 64;

    typedef struct packed {
        logic [63:0] d;
        logic        l;
        logic [2:0]  bn;
    } lane_t;

    logic             clk = 1'b0;
    logic             reset, start, bus_data_valid, read_done, buffer_full;
    logic [15:0]      msg_len;
    logic [BUS_W-1:0] ocm_data_out;
    logic             read_ready, init_master_txn, in_ready, is_last, busy, done;
    logic [31:0]      read_addr_index;
    logic [63:0]      keccak_input;
    logic [2:0]       byte_num;
    logic [104:0]     outs_s;

    lane_t exp_lanes[$];
    int    exp_bursts[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    n_issued = 0;
    int    beats_sent = 0;
    int    cur_tag = 0;
    int    bf_mode = 0;
    logic  bf_seen = 1'b0;

    keccak_stream_feeder #(.BUS_W(BUS_W), .BEATS_PER_BURST(BPB), .FIFO_DEPTH(8), .LEN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .msg_len(msg_len),
        .ocm_data_out(ocm_data_out), .bus_data_valid(bus_data_valid),
        .read_ready(read_ready), .read_addr_index(read_addr_index),
        .init_master_txn(init_master_txn), .read_done(read_done),
        .keccak_input(keccak_input), .in_ready(in_ready), .is_last(is_last),
        .byte_num(byte_num), .buffer_full(buffer_full), .busy(busy), .done(done)
    );

    assign outs_s = {read_ready, read_addr_index, init_master_txn, keccak_input,
                     in_ready, is_last, byte_num, busy, done};

    initial forever #5 clk = ~clk;

    function automatic logic [63:0] lane_word(input int tag, input int g);
        logic [31:0] tv, gv;
        tv = tag;
        gv = g;
        return {16'hC0DE, tv[15:0], gv};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected bursts and lanes for one message, built from the length alone
    task automatic expect_msg(input int len, input int tag);
        lane_t e;
        int nb = (len + BURST_BYTES - 1) / BURST_BYTES;
        for (int i = 0; i < nb; i++) exp_bursts.push_back(i);
        for (int i = 0; i < len / 8; i++) begin
            e.d = lane_word(tag, i); e.l = 1'b0; e.bn = 3'd0;
            exp_lanes.push_back(e);
        end
        e.l  = 1'b1;
        e.bn = 3'(len % 8);
        e.d  = (len % 8 != 0) ? lane_word(tag, len / 8) : 64'd0;
        exp_lanes.push_back(e);
    endtask

    task automatic start_msg(input int len, input int tag);
        cur_tag = tag;
        expect_msg(len, tag);
        msg_len = 16'(len);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 1;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic end_msg();
        @(negedge clk);
        chk("busy_low", busy, 0);
        chk("lanes_left", exp_lanes.size(), 0);
        chk("bursts_left", exp_bursts.size(), 0);
        chk("overflow_flag", dut.ovf_q, 0);
    endtask

    // Core backpressure: 0 = ready, 1 = toggle every cycle, 2 = held full
    initial begin
        buffer_full = 1'b0;
        forever begin
            @(negedge clk);
            case (bf_mode)
                0:       buffer_full = 1'b0;
                1:       buffer_full = ~buffer_full;
                default: buffer_full = 1'b1;
            endcase
        end
    end

    always @(posedge clk) bf_seen <= buffer_full;

    // Burst-master model: BPB beats after each request, read_done with the last one
    initial begin : master
        int m_idx, m_beat;
        logic m_active;
        logic [BUS_W-1:0] beat;
        m_active = 1'b0; m_idx = 0; m_beat = 0;
        bus_data_valid = 1'b0; read_done = 1'b0; ocm_data_out = '0;
        forever begin
            @(negedge clk);
            bus_data_valid = 1'b0;
            read_done      = 1'b0;
            if (reset) begin
                m_active = 1'b0;
            end else if (m_active) begin
                for (int k = 0; k < LANES; k++)
                    beat[k*64 +: 64] = lane_word(cur_tag, m_idx*BPB*LANES + m_beat*LANES + k);
                ocm_data_out   = beat;
                bus_data_valid = 1'b1;
                beats_sent++;
                if (m_beat == BPB - 1) begin
                    read_done = 1'b1;
                    m_active  = 1'b0;
                end else begin
                    m_beat++;
                end
            end else if (init_master_txn) begin
                m_active = 1'b1;
                m_idx    = int'(read_addr_index);
                m_beat   = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a burst request or a lane
    initial begin : monitor
        lane_t act, e;
        int eb;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (init_master_txn) begin
                    n_issued++;
                    chk("burst_expected", exp_bursts.size() != 0, 1);
                    if (exp_bursts.size() != 0) begin
                        eb = exp_bursts.pop_front();
                        chk("burst_index", read_addr_index, eb);
                    end
                end
                if (in_ready) begin
                    chk("in_ready_vs_buffer_full", bf_seen, 0);
                    chk("lane_expected", exp_lanes.size() != 0, 1);
                    if (exp_lanes.size() != 0) begin
                        e = exp_lanes.pop_front();
                        act.d = keccak_input; act.l = is_last; act.bn = byte_num;
                        chk("lane", act, e);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog timeout");
    end

    initial begin : main
        int cyc, base, k;
        reset = 1'b1; start = 1'b0; msg_len = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_s, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 64 bytes: 8 full lanes then an empty is_last lane
        base = n_issued;
        start_msg(64, 1);
        wait_done(500, cyc);
        end_msg();
        chk("msg64_bursts", n_issued - base, 1);

        // 13 bytes: one full lane, 5-byte final lane, rest of the burst flushed
        base = n_issued;
        start_msg(13, 2);
        wait_done(500, cyc);
        end_msg();
        chk("msg13_bursts", n_issued - base, 1);

        // zero length: no burst, a single empty is_last lane, done quickly
        base = n_issued;
        start_msg(0, 3);
        wait_done(20, cyc);
        chk("zero_len_done_latency", cyc <= 4, 1);
        end_msg();
        chk("zero_len_bursts", n_issued - base, 0);

        // 200 bytes with toggling backpressure and a start pulse while busy
        base = n_issued;
        bf_mode = 1;
        start_msg(200, 4);
        repeat (10) @(negedge clk);
        msg_len = 16'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000, cyc);
        bf_mode = 0;
        end_msg();
        chk("msg200_bursts", n_issued - base, 4);

        // core stalled: FIFO fills, read_ready drops and issue pauses until release
        base = n_issued;
        bf_mode = 2;
        start_msg(200, 5);
        repeat (60) @(negedge clk);
        chk("fill_read_ready", read_ready, 0);
        chk("fill_bursts_paused", n_issued - base, 2);
        bf_mode = 0;
        wait_done(3000, cyc);
        end_msg();
        chk("fill_bursts_total", n_issued - base, 4);

        // reset in the middle of a burst, then a clean 8-byte message
        base = beats_sent;
        start_msg(200, 6);
        k = 0;
        while (beats_sent == base && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mid_burst_reached", beats_sent != base, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", outs_s, 0);
        exp_lanes.delete();
        exp_bursts.delete();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        base = n_issued;
        start_msg(8, 7);
        wait_done(500, cyc);
        end_msg();
        chk("after_reset_bursts", n_issued - base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
